// File: rtl/minilab_pkg.sv
// Shared lab package: Avalon-MM width defaults, ROM geometry and the default ROM fill pattern.
package minilab_pkg;

    localparam int AVMM_DATA_WIDTH = 64;
    localparam int AVMM_ADDR_WIDTH = 32;
    localparam int ROM_DEPTH       = 16;
    localparam int RD_LATENCY      = 3;

    typedef logic [3:0] pend_t;
    typedef logic [7:0] oor_cnt_t;

    // Every byte of ROM word idx defaults to idx+1, so word 0 reads as all 8'h01.
    function automatic logic [7:0] fill_byte(input int unsigned idx);
        return 8'(idx + 1);
    endfunction

endpackage

// File: rtl/avmm_rom_responder_if.sv
// Avalon-MM read-only command/response bundle between a master and the ROM responder.
interface avmm_rom_responder_if
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH = AVMM_DATA_WIDTH,
    parameter int ADDR_WIDTH = AVMM_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/rd_latency_pipe.sv
// Fixed-latency shift pipeline carrying a valid bit and a ROM index from accept to response.
module rd_latency_pipe
    import minilab_pkg::*;
#(
    parameter int LATENCY     = RD_LATENCY,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [INDEX_WIDTH-1:0] i_index,
    output logic                   o_pop,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic [LATENCY-1:0]     r_valid;
    logic [INDEX_WIDTH-1:0] r_index [LATENCY];

    // Stage 0 loads on the accept edge; the last stage feeds the response register in the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_index[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_push;
            r_index[0] <= i_index;
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_index[k] <= r_index[k-1];
            end
        end
    end

    assign o_pop   = r_valid[LATENCY-1];
    assign o_index = r_index[LATENCY-1];

endmodule

// File: rtl/avmm_rom_responder.sv
// Avalon-MM read-only ROM slave with programmable stall cycles, fixed read latency,
// an in-flight read cap and a saturating out-of-range read counter.
module avmm_rom_responder
    import minilab_pkg::*;
#(
    parameter int    DATA_WIDTH  = AVMM_DATA_WIDTH,
    parameter int    ADDR_WIDTH  = AVMM_ADDR_WIDTH,
    parameter int    DEPTH       = ROM_DEPTH,
    parameter int    LATENCY     = RD_LATENCY,
    parameter int    WAIT_CYCLES = 2,
    parameter int    MAX_PENDING = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    avmm_rom_responder_if.slave  bus,
    output pend_t                pending,
    output oor_cnt_t             oor_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]            r_stallCnt;
    pend_t                 r_pending;
    oor_cnt_t              r_oorCount;
    logic                  r_readdatavalid;
    logic [DATA_WIDTH-1:0] r_readdata;

    logic                  w_stall;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_inRange;
    logic [IDX_W:0]        w_pushIndex;
    logic                  w_pop;
    logic [IDX_W:0]        w_popIndex;
    logic                  w_popOor;
    logic [IDX_W-1:0]      w_popIdx;
    logic [DATA_WIDTH-1:0] w_romWord;

    // Stall depends only on registered state (and reset), never on the incoming read.
    assign w_stall          = (r_stallCnt < 4'(WAIT_CYCLES));
    assign w_full           = (r_pending == 4'(MAX_PENDING));
    assign bus.waitrequest  = rst | w_stall | w_full;
    assign w_accept         = bus.read & ~bus.waitrequest;

    assign w_inRange   = (bus.address < ADDR_WIDTH'(DEPTH));
    assign w_pushIndex = {~w_inRange, bus.address[IDX_W-1:0]};

    rd_latency_pipe #(
        .LATENCY     (LATENCY),
        .INDEX_WIDTH (IDX_W + 1)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_index (w_pushIndex),
        .o_pop   (w_pop),
        .o_index (w_popIndex)
    );

    assign w_popOor = w_popIndex[IDX_W];
    assign w_popIdx = w_popIndex[IDX_W-1:0];

    // ROM image is built from the package fill pattern.
    logic [DATA_WIDTH-1:0] w_rom [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        assign w_rom[gi] = {(DATA_WIDTH/8){fill_byte(gi)}};
    end
    assign w_romWord = w_rom[w_popIdx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_accept) begin
            r_stallCnt <= '0;
        end else if (bus.read && bus.waitrequest && w_stall) begin
            r_stallCnt <= r_stallCnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_pending <= r_pending + 4'd1;
                2'b01:   r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Response edge: data is captured only here so readdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readdatavalid <= 1'b0;
            r_readdata      <= '0;
            r_oorCount      <= '0;
        end else begin
            r_readdatavalid <= w_pop;
            if (w_pop) begin
                r_readdata <= w_popOor ? '0 : w_romWord;
                if (w_popOor && (r_oorCount != 8'hFF)) begin
                    r_oorCount <= r_oorCount + 8'd1;
                end
            end
        end
    end

    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_readdatavalid;
    assign pending           = r_pending;
    assign oor_count         = r_oorCount;

endmodule
